// File: rtl/add_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// add_seq_pkg
//   Shared definitions for the nibble-serial adder controller.
//   NIB_W      : width of one datapath slice (the 4-bit ripple adder)
//   state_t    : controller states IDLE / RUN / DONE
//   idx_width(): width of the nibble index counter, never below 1 bit
// ----------------------------------------------------------------------------
package add_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // $clog2(1) is 0, which would give a zero-width counter; clamp to 1 bit.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/add_seq_ctrl_fulladder4.sv
// ----------------------------------------------------------------------------
// fullAdder4
//   4-bit ripple-carry adder used as the shared nibble datapath of
//   add_seq_ctrl. Purely combinational.
// Ports
//   a    in  4  addend A nibble
//   b    in  4  addend B nibble
//   cin  in  1  carry into bit 0
//   sum  out 4  sum nibble
//   cout out 1  carry out of bit 3
// ----------------------------------------------------------------------------
module fullAdder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bit
         assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
      end
   endgenerate

   assign cout = carry[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// ----------------------------------------------------------------------------
// add_seq_ctrl
//   Multi-cycle wide adder. On an accepted start the operands and carry-in are
//   latched, then one nibble per clock is pushed through a single fullAdder4,
//   LSB first, with the carry held in a register between nibbles. After
//   NIBBLES RUN cycles the controller enters DONE for one cycle (done pulse);
//   the result stays on sum/cout until the next accepted start.
//
// Parameters
//   NIBBLES  operand width in nibbles (1..8); W = 4*NIBBLES
//
// Ports
//   clk    in   1  clock, rising edge
//   reset  in   1  asynchronous active-high reset, clears all state
//   start  in   1  request, sampled only in IDLE or DONE
//   a      in   W  operand A, latched on accepted start
//   b      in   W  operand B, latched on accepted start
//   cin    in   1  carry into nibble 0, latched on accepted start
//   sub    in   1  subtract select (only with ADD_SEQ_SUB_EN)
//   busy   out  1  high while in RUN
//   done   out  1  one-cycle result-valid pulse
//   sum    out  W  result
//   cout   out  1  carry out of the top nibble
//
// Build option
//   ADD_SEQ_SUB_EN : adds the sub port. A latched sub=1 inverts B and forces
//                    the carry-in to 1, so sum = a - b and cout = no-borrow.
// ----------------------------------------------------------------------------
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIB_W * NIBBLES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef ADD_SEQ_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int               IDX_W    = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [W-1:0]       opa_q,   opa_d;
   logic [W-1:0]       opb_q,   opb_d;
   logic [W-1:0]       sum_q,   sum_d;
   logic               carry_q, carry_d;
   logic               cout_q,  cout_d;

   logic [NIB_W-1:0]   nib_a;
   logic [NIB_W-1:0]   nib_b;
   logic [NIB_W-1:0]   nib_sum;
   logic               nib_cout;

   // ------------------------------------------------------------------
   // Operand nibble selection. A compare-per-nibble mux keeps every part
   // select constant, so no index can ever point past the operand.
   // ------------------------------------------------------------------
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_a = opa_q[i*NIB_W +: NIB_W];
            nib_b = opb_q[i*NIB_W +: NIB_W];
         end
      end
   end

   fullAdder4 u_nib_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      case (state_q)
         RUN: begin
            // start is deliberately ignored here: no re-latch, no queueing.
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[i*NIB_W +: NIB_W] = nib_sum;
               end
            end
            carry_d = nib_cout;
            if (idx_q == IDX_LAST) begin
               cout_d  = nib_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
            end
         end

         default: begin
            // IDLE and DONE both accept a new request; DONE falls back to
            // IDLE otherwise so done is a single-cycle pulse.
            if (start) begin
               opa_d   = a;
`ifdef ADD_SEQ_SUB_EN
               opb_d   = sub ? ~b : b;
               carry_d = sub | cin;
`else
               opb_d   = b;
               carry_d = cin;
`endif
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_add_seq_ctrl
//   Bench for add_seq_ctrl: a 16-bit instance (NIBBLES=4) for the directed,
//   random, mid-run, back-to-back and reset cases, plus a NIBBLES=1 instance
//   swept over every (a, b, cin). Reference results come from plain integer
//   arithmetic on the request, not from the controller's structure.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_add_seq_ctrl;

`ifdef ADD_SEQ_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        start4 = 1'b0;
   logic [15:0] a4 = '0, b4 = '0;
   logic        cin4 = 1'b0, sub4 = 1'b0;
   logic        busy4, done4, cout4;
   logic [15:0] sum4;

   logic        start1 = 1'b0;
   logic [3:0]  a1 = '0, b1 = '0;
   logic        cin1 = 1'b0, sub1 = 1'b0;
   logic        busy1, done1, cout1;
   logic [3:0]  sum1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   add_seq_ctrl #(.NIBBLES(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
`ifdef ADD_SEQ_SUB_EN
      .sub   (sub4),
`endif
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4)
   );

   add_seq_ctrl #(.NIBBLES(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
`ifdef ADD_SEQ_SUB_EN
      .sub   (sub1),
`endif
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   // Reference: {cout,sum} of the requested operation on 16-bit operands.
   function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic sb);
      logic [16:0] r;
      if (SUB_EN && sb) r = {1'b0, x} + {1'b0, ~y} + 17'd1;
      else              r = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      return r;
   endfunction

   // Issue one request to the 16-bit instance and wait for done.
   // lat = sample number (1 = first negedge after the accepting edge) at
   // which done was seen, 0 on timeout; nbusy = samples with busy high.
   task automatic run_op4(input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb,
                          output int lat, output int nbusy,
                          output logic [15:0] rs, output logic rc);
      lat = 0; nbusy = 0; rs = 'x; rc = 1'bx;
      @(negedge clk);
      a4 = x; b4 = y; cin4 = ci; sub4 = sb; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (busy4) nbusy++;
         if (done4) begin
            lat = k; rs = sum4; rc = cout4;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if ({busy4, done4, cout4, sum4} !== 19'd0) begin
         errors++;
         $display("FAIL reset_async: busy=%b done=%b cout=%b sum=%h required all zero", busy4, done4, cout4, sum4);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({busy4, done4, cout4, sum4, busy1, done1, cout1, sum1} !== 26'd0) begin
         errors++;
         $display("FAIL reset_state: dut4 busy=%b done=%b cout=%b sum=%h dut1 busy=%b done=%b cout=%b sum=%h required zero",
                  busy4, done4, cout4, sum4, busy1, done1, cout1, sum1);
      end
      reset = 1'b0;
      $display("reset: outputs checked");
   endtask

   task automatic test_directed();
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic        vc [3];
      int lat, nbusy;
      logic [15:0] rs;
      logic rc;
      logic [16:0] exp;
      va = '{16'h00FF, 16'hFFFF, 16'h1234};
      vb = '{16'h0001, 16'h0001, 16'h4321};
      vc = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         run_op4(va[i], vb[i], vc[i], 1'b0, lat, nbusy, rs, rc);
         exp = ref16(va[i], vb[i], vc[i], 1'b0);
         $display("directed %0d: a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d busy=%0d", i, va[i], vb[i], vc[i], rs, rc, lat, nbusy);
         checks++;
         if ({rc, rs} !== exp) begin
            errors++;
            $display("FAIL directed_result %0d: got %h required %h", i, {rc, rs}, exp);
         end
         checks++;
         if (lat !== 5 || nbusy !== 4) begin
            errors++;
            $display("FAIL directed_timing %0d: lat=%0d busy=%0d required lat=5 busy=4", i, lat, nbusy);
         end
         @(negedge clk);
         checks++;
         if (done4 !== 1'b0 || {cout4, sum4} !== exp) begin
            errors++;
            $display("FAIL directed_hold %0d: done=%b result=%h required done=0 result=%h", i, done4, {cout4, sum4}, exp);
         end
      end
   endtask

   task automatic test_random();
      int lat, nbusy;
      logic [15:0] x, y, rs;
      logic ci, sb, rc;
      logic [16:0] exp;
      for (int i = 0; i < 30; i++) begin
         x  = 16'($urandom);
         y  = 16'($urandom);
         ci = 1'($urandom);
         sb = SUB_EN ? 1'($urandom) : 1'b0;
         run_op4(x, y, ci, sb, lat, nbusy, rs, rc);
         exp = ref16(x, y, ci, sb);
         $display("random %0d: a=%h b=%h cin=%b sub=%b -> %h exp %h lat=%0d", i, x, y, ci, sb, {rc, rs}, exp, lat);
         checks++;
         if ({rc, rs} !== exp || lat !== 5) begin
            errors++;
            $display("FAIL random %0d: got %h lat=%0d required %h lat=5", i, {rc, rs}, lat, exp);
         end
      end
   endtask

   // Operands change and start re-pulses while the operation is running.
   task automatic test_mid_run();
      int lat;
      logic [16:0] exp;
      exp = ref16(16'h1234, 16'h4321, 1'b1, 1'b0);
      lat = 0;
      @(negedge clk);
      a4 = 16'h1234; b4 = 16'h4321; cin4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      checks++;
      if (sum4 !== 16'h0000 || busy4 !== 1'b1) begin
         errors++;
         $display("FAIL mid_run_accept: sum=%h busy=%b required sum=0000 busy=1", sum4, busy4);
      end
      for (int k = 1; k <= 20; k++) begin
         if (k <= 2) begin
            a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom); start4 = 1'b1;
         end else begin
            start4 = 1'b0;
         end
         if (done4) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      start4 = 1'b0;
      $display("mid_run: result=%h lat=%0d", {cout4, sum4}, lat);
      checks++;
      if ({cout4, sum4} !== exp || lat !== 5) begin
         errors++;
         $display("FAIL mid_run_result: got %h lat=%0d required %h lat=5", {cout4, sum4}, lat, exp);
      end
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_no_requeue: busy=%b done=%b required 0 0", busy4, done4);
      end
   endtask

   task automatic test_back_to_back();
      int lat, nbusy;
      logic [15:0] rs, x, y;
      logic rc;
      logic [16:0] exp;
      run_op4(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, lat, nbusy, rs, rc);
      checks++;
      if ({rc, rs} !== ref16(16'hA5A5, 16'h5A5B, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL b2b_first: got %h required %h", {rc, rs}, ref16(16'hA5A5, 16'h5A5B, 1'b0, 1'b0));
      end
      // Still in the DONE cycle: request the next operation right away.
      x = 16'($urandom); y = 16'($urandom);
      exp = ref16(x, y, 1'b1, 1'b0);
      a4 = x; b4 = y; cin4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      checks++;
      if (busy4 !== 1'b1 || {cout4, sum4} !== 17'd0) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b result=%h required busy=1 result=00000", busy4, {cout4, sum4});
      end
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         if (done4) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      $display("back_to_back: a=%h b=%h -> %h lat=%0d", x, y, {cout4, sum4}, lat);
      checks++;
      if ({cout4, sum4} !== exp || lat !== 5) begin
         errors++;
         $display("FAIL b2b_second: got %h lat=%0d required %h lat=5", {cout4, sum4}, lat, exp);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones;
      dones = 0;
      @(negedge clk);
      a4 = 16'h0123; b4 = 16'h0001; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
      @(negedge clk);          // first RUN cycle
      start4 = 1'b0;
      @(negedge clk);          // second RUN cycle, nibble 0 already written
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({busy4, done4, cout4, sum4} !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b done=%b cout=%b sum=%h required all zero", busy4, done4, cout4, sum4);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done4 || busy4) dones++;
      end
      $display("reset_mid_run: activity after reset=%0d sum=%h", dones, sum4);
      checks++;
      if (dones !== 0 || sum4 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_no_done: activity=%0d sum=%h required 0 0000", dones, sum4);
      end
   endtask

   task automatic test_sub();
      int lat, nbusy;
      logic [15:0] rs;
      logic rc;
      run_op4(16'h0005, 16'h0007, 1'b0, 1'b1, lat, nbusy, rs, rc);
      $display("sub: 5-7 -> sum=%h cout=%b", rs, rc);
      checks++;
      if (rs !== 16'hFFFE || rc !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: got sum=%h cout=%b required FFFE 0", rs, rc);
      end
      run_op4(16'h0007, 16'h0005, 1'b0, 1'b1, lat, nbusy, rs, rc);
      $display("sub: 7-5 -> sum=%h cout=%b", rs, rc);
      checks++;
      if (rs !== 16'h0002 || rc !== 1'b1) begin
         errors++;
         $display("FAIL sub_noborrow: got sum=%h cout=%b required 0002 1", rs, rc);
      end
   endtask

   task automatic test_exhaustive_n1();
      int lat;
      logic [4:0] exp;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int c = 0; c < 2; c++) begin
               exp = 5'(x + y + c);
               @(negedge clk);
               a1 = 4'(x); b1 = 4'(y); cin1 = 1'(c); sub1 = 1'b0; start1 = 1'b1;
               @(negedge clk);
               start1 = 1'b0;
               lat = 0;
               for (int k = 1; k <= 8; k++) begin
                  if (done1) begin
                     lat = k;
                     break;
                  end
                  @(negedge clk);
               end
               $display("n1: a=%h b=%h cin=%0d -> %h exp %h lat=%0d", x[3:0], y[3:0], c, {cout1, sum1}, exp, lat);
               checks++;
               if ({cout1, sum1} !== exp || lat !== 2) begin
                  errors++;
                  $display("FAIL n1_sum a=%0d b=%0d cin=%0d: got %h lat=%0d required %h lat=2", x, y, c, {cout1, sum1}, lat, exp);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_mid_run();
      test_back_to_back();
      test_reset_mid_run();
      if (SUB_EN) test_sub();
      test_exhaustive_n1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
